// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the iterative multiply/divide unit.
//   op_e    : issue operation codes (6 and 7 are reserved and behave as no-ops)
//   state_e : control FSM states
//   is_multicycle / is_signed_op : op classification helpers
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic is_multicycle(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one combinational iteration of the multiply/divide datapath.
//   acc      : 2*WIDTH accumulator. Multiply: {partial product, multiplier}.
//              Divide: {partial remainder, dividend/quotient bits}.
//   operand  : multiplicand (multiply) or divisor (divide), magnitude form
//   div_mode : 0 = shift-add step, 1 = restoring-subtract step
//   acc_next : accumulator after this step
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               div_mode,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] diff;

  always_comb begin
    // Multiply: add multiplicand when the current multiplier LSB is set,
    // keep the carry, then shift the whole accumulator right by one.
    addend = acc[0] ? operand : {WIDTH{1'b0}};
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    // Divide: remainder shifted left with the next dividend bit; needs
    // WIDTH+1 bits since the remainder can reach divisor-1 before the shift.
    shl    = acc[2*WIDTH-1:WIDTH-1];
    // Only used when shl >= operand, so the true difference fits WIDTH bits.
    diff   = shl[WIDTH-1:0] - operand;
    if (div_mode) begin
      if (shl >= {1'b0, operand})
        acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers, plus
// single-cycle MTHI/MTLO, for use beside the EX-stage ALU.
//   clock, reset      : clock; asynchronous active-high reset
//   in_valid/in_ready : issue handshake (ready only in IDLE)
//   op, a, b          : operation, rs operand, rt operand
//   abort             : pipeline flush; cancels a RUN/FIX operation
//   busy              : high in RUN or FIX (hazard unit stalls MFHI/MFLO)
//   done              : one-cycle pulse after a multi-cycle HI/LO update
//   hi, lo            : HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_orig;
  logic               is_div, neg_q, neg_r, div_zero;

  // Accept-side operand conditioning
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;

  // FIX-side sign correction
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_comb begin
    a_neg = is_signed_op(op) & a[WIDTH-1];
    b_neg = is_signed_op(op) & b[WIDTH-1];
    // The most-negative value maps to 2^(WIDTH-1), which is fine unsigned.
    mag_a = a_neg ? -a : a;
    mag_b = b_neg ? -b : b;
  end

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .acc      (acc),
    .operand  (opnd),
    .div_mode (is_div),
    .acc_next (acc_nxt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      a_orig   <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (is_multicycle(op)) begin
              is_div   <= (op == OP_DIV) || (op == OP_DIVU);
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= a_neg;
              div_zero <= (b == '0);
              a_orig   <= a;
              cnt      <= '0;
              // Multiply keeps the multiplier in the low half and the
              // multiplicand as operand; divide starts with the dividend low.
              if ((op == OP_DIV) || (op == OP_DIVU)) begin
                acc  <= {{WIDTH{1'b0}}, mag_a};
                opnd <= mag_b;
              end else begin
                acc  <= {{WIDTH{1'b0}}, mag_b};
                opnd <= mag_a;
              end
              state <= S_RUN;
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end
            // reserved ops: accepted, nothing happens
          end
        end
        S_RUN: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!abort) begin
            done <= 1'b1;
            if (!is_div) begin
              {hi, lo} <= prod_fix;
            end else if (div_zero) begin
              hi <= a_orig;
              lo <= {WIDTH{1'b1}};
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with HI/LO result registers, to be added beside the EX-stage ALU of the 5-stage MIPS pipeline. It executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in a single cycle. It exposes a ready/valid issue handshake and a busy flag that the hazard unit uses to stall dependent MFHI/MFLO. It supports abort from pipeline flush.

Parameters:
WIDTH, 32, operand and HI/LO register width; must be at least 2.
CNT_W, $clog2(WIDTH)+1, width of the iteration counter. Derived; do not override.

Ports:
clock  in  1  single clock; all state changes on rising edge.
reset  in  1  asynchronous, active-high; clears all state.
in_valid  in  1  issue request from EX.
in_ready  out  1  high in IDLE; the operation is accepted on an edge where in_valid && in_ready.
op  in  3  operation code (see package).
a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source).
b  in  WIDTH  rt operand (divisor / multiplier).
abort  in  1  flush; cancels an in-flight multi-cycle operation.
busy  out  1  high in RUN or FIX.
done  out  1  one-cycle pulse; HI/LO have just been updated by a multi-cycle operation.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, hi=0, lo=0, done=0, busy=0, in_ready=1, counter=0.
- States: IDLE, RUN, FIX.
- IDLE, accept of MULT/MULTU/DIV/DIVU:
  - Latch the operand magnitudes (abs value for signed ops, raw for unsigned), the sign flags, and the op.
  - counter=0; go to RUN.
- IDLE, accept of MTHI/MTLO: hi<=a or lo<=a on that edge; stay in IDLE; done stays 0.
- IDLE, accept of reserved op (6, 7): accepted as a no-op.
- RUN: one iteration per edge; counter increments; go to FIX after the edge where counter==WIDTH-1 (exactly WIDTH edges).
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring subtract, one quotient bit per iteration.
- FIX: on its edge, apply sign correction, load hi/lo, assert done for the following cycle, go to IDLE.
- Latency: accept at edge t -> hi/lo/done valid after edge t+WIDTH+1. in_ready is high in the done cycle, so back-to-back issue is allowed.
- Multiply results: {hi,lo} = full 2*WIDTH product. Signed ops negate the product if the operand signs differ.
- Divide results: lo=quotient, hi=remainder.
  - Signed: quotient negative iff the signs differ; remainder takes the dividend's sign.
  - Most-negative / -1: lo=most-negative value (wraps), hi=0.
- Divide by zero (b==0, signed or unsigned): lo={WIDTH{1}}, hi=a original, written at the FIX edge; normal latency.
- abort:
  - In RUN or FIX: return to IDLE on the next edge; hi/lo unchanged; no done.
  - In IDLE: no effect. Abort takes priority over the FIX load.
  - abort and in_valid in the same IDLE cycle: the issue is accepted.
- in_valid while busy: ignored (in_ready=0). The issuer holds the request and the pipeline stalls.
- Reset mid-operation: immediate return to reset values; partial result discarded.
- done is registered and never asserted for MTHI/MTLO or an aborted op.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings: OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MTHI=4, OP_MTLO=5;
  - state encodings: S_IDLE, S_RUN, S_FIX;
  - helper function is_multicycle(op).
- One sub-module, muldiv_iter: combinational single-iteration step for both shift-add and restoring subtract. Parametrised by WIDTH; takes the accumulator, operand and a mode bit; returns the next accumulator.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done 33 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=-3 b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100 b=7 -> lo=0xE, hi=0x2.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF, hi=0x1234.
- MTHI 0xAAAA0000 then MTLO 0x5555 on consecutive edges -> hi/lo update the edge after each; done never asserted; in_ready stays 1.
- Issue MULTU, assert abort at RUN cycle 10 -> IDLE next edge, hi/lo keep prior values, no done. MTLO held with in_valid during RUN is not accepted until IDLE.
- Assert reset at RUN cycle 5 of DIVU -> asynchronously hi=lo=0, busy=0, in_ready=1. Re-issue DIVU 9/3 -> lo=3, hi=0.
